// File: rtl/aes_link_pkg.sv
// Shared types, geometry helpers and FIPS-197 reference vectors for the AES serial link.
package aes_link_pkg;

  typedef enum logic {PH_LOAD = 1'b0, PH_UNLOAD = 1'b1} phase_t;
  typedef enum logic [1:0] {IDLE, SHIFT_IN, SHIFT_OUT} state_t;

  function automatic int dataBits(input int nb);
    return 32 * nb;
  endfunction

  function automatic int keyBits(input int nk);
    return 32 * nk;
  endfunction

  // Default geometry: AES-128 (Nb=4, Nk=4)
  localparam int DATA_BITS  = dataBits(4);
  localparam int KEY_BITS   = keyBits(4);
  localparam int LOAD_LEN   = DATA_BITS + KEY_BITS;
  localparam int UNLOAD_LEN = DATA_BITS;

  localparam logic [127:0] FIPS_PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] FIPS_KEY256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

endpackage

// File: rtl/aes_bit_shifter.sv
// LSB-first shift register: serial bits enter at the MSB and leave at q[0]; one-cycle load/shift, no backpressure.
module aes_bit_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         en,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst)      q <= '0;
    else if (load) q <= loadVal;
    else if (en)   q <= {sin, q[W-1:1]};
  end

endmodule

// File: rtl/aes_serial_port.sv
// cs/miso/mosi responder for an AES core: blk_valid rises the cycle after the last LOAD bit and holds until blk_ready;
// LOADs arriving while the core side is busy are dropped. Optional sticky err port: define AES_SERIAL_ERR_EN.
module aes_serial_port
  import aes_link_pkg::*;
#(
  parameter int Nb    = 4,
  parameter int Nk    = 4,
  parameter int CNT_W = $clog2(32*Nb + 32*Nk + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             miso,
  output logic             mosi,
  output logic [32*Nb-1:0] blk_data,
  output logic [32*Nk-1:0] blk_key,
  output logic             blk_valid,
  input  logic             blk_ready,
  input  logic [32*Nb-1:0] res_data,
  input  logic             res_valid,
  output logic             res_ready,
  output logic             busy
`ifdef AES_SERIAL_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int DBITS = dataBits(Nb);
  localparam int LLEN  = DBITS + keyBits(Nk);
  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(LLEN);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(DBITS);

  state_t            state, stateNext;
  phase_t            phase;
  logic              csQ, start, coreIdle;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic              loadOk, outActive, resHeld, resFresh;
  logic              blkValidQ, resReadyQ, mosiQ, mosiNext;
  logic              shInEn, shOutLoad, shOutEn, inDone, outDone;
  logic [DBITS-1:0]  resReg, outQ;
  logic [LLEN-1:0]   inQ;
  logic              unusedOutQ;

  assign start     = !cs && csQ;
  assign coreIdle  = !blkValidQ && !resReadyQ;
  assign unusedOutQ = ^outQ[DBITS-1:1];

  aes_bit_shifter #(.W(LLEN)) inShift (
    .clk(clk), .rst(rst), .load(1'b0), .loadVal('0),
    .en(shInEn), .sin(miso), .q(inQ)
  );

  // Preloaded with result[DBITS-1:1]: bit 0 goes out directly on the start edge.
  aes_bit_shifter #(.W(DBITS)) outShift (
    .clk(clk), .rst(rst), .load(shOutLoad), .loadVal({1'b0, resReg[DBITS-1:1]}),
    .en(shOutEn), .sin(1'b0), .q(outQ)
  );

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    shInEn    = 1'b0;
    shOutLoad = 1'b0;
    shOutEn   = 1'b0;
    mosiNext  = 1'b0;
    inDone    = 1'b0;
    outDone   = 1'b0;
    if (start) begin
      cntNext = CNT_W'(1);
      if (phase == PH_LOAD) begin
        stateNext = SHIFT_IN;
      end else begin
        stateNext = SHIFT_OUT;
        shOutLoad = 1'b1;
        mosiNext  = resHeld & resReg[0];
      end
    end else begin
      unique case (state)
        SHIFT_IN: begin
          shInEn = loadOk;
          if (cnt == IN_LAST) begin
            stateNext = IDLE;
            inDone    = loadOk;
          end else begin
            cntNext = cnt + 1'b1;
          end
        end
        SHIFT_OUT: begin
          if (cnt == OUT_LAST) begin
            stateNext = IDLE;
            outDone   = outActive;
          end else begin
            shOutEn  = 1'b1;
            mosiNext = outActive & outQ[0];
            cntNext  = cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      phase     <= PH_LOAD;
      csQ       <= 1'b1;
      cnt       <= '0;
      loadOk    <= 1'b0;
      outActive <= 1'b0;
      mosiQ     <= 1'b0;
      blkValidQ <= 1'b0;
      resReadyQ <= 1'b0;
      resHeld   <= 1'b0;
      resFresh  <= 1'b0;
      resReg    <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      csQ   <= cs;
      mosiQ <= mosiNext;
      if (start) begin
        phase <= (phase == PH_LOAD) ? PH_UNLOAD : PH_LOAD;
        if (phase == PH_LOAD) begin
          loadOk <= coreIdle;
        end else begin
          outActive <= resHeld;
          resFresh  <= 1'b0;
        end
      end
      if (inDone) begin
        blkValidQ <= 1'b1;
      end else if (blkValidQ && blk_ready) begin
        blkValidQ <= 1'b0;
        resReadyQ <= 1'b1;
      end
      // A result captured while an UNLOAD is shifting must survive that frame's end.
      if (resReadyQ && res_valid) begin
        resReg    <= res_data;
        resHeld   <= 1'b1;
        resReadyQ <= 1'b0;
        resFresh  <= 1'b1;
      end else if (outDone && !resFresh) begin
        resHeld <= 1'b0;
      end
    end
  end

`ifdef AES_SERIAL_ERR_EN
  logic errQ;
  always_ff @(posedge clk) begin
    if (!rst) errQ <= 1'b0;
    else if (start && ((phase == PH_LOAD) ? !coreIdle : !resHeld)) errQ <= 1'b1;
  end
  assign err = errQ;
`endif

  assign mosi      = mosiQ;
  assign blk_data  = inQ[DBITS-1:0];
  assign blk_key   = inQ[LLEN-1:DBITS];
  assign blk_valid = blkValidQ;
  assign res_ready = resReadyQ;
  assign busy      = (state == SHIFT_IN) || (state == SHIFT_OUT);

endmodule

// File: tb/tb_aes_serial_port.sv
// Directed bench for aes_serial_port: an AES-128 instance for the frame protocol and an Nk=8 instance for the long key.
module tb_aes_serial_port;
  import aes_link_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic csA, misoA, mosiA, blkValidA, blkReadyA, resValidA, resReadyA, busyA;
  logic [127:0] blkDataA, blkKeyA, resDataA;
  logic csB, misoB, mosiB, blkValidB, blkReadyB, resValidB, resReadyB, busyB;
  logic [127:0] blkDataB, resDataB;
  logic [255:0] blkKeyB;
`ifdef AES_SERIAL_ERR_EN
  logic errA, errB;
`endif

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  aes_serial_port #(.Nb(4), .Nk(4)) dutA (
    .clk(clk), .rst(rst), .cs(csA), .miso(misoA), .mosi(mosiA),
    .blk_data(blkDataA), .blk_key(blkKeyA), .blk_valid(blkValidA), .blk_ready(blkReadyA),
    .res_data(resDataA), .res_valid(resValidA), .res_ready(resReadyA),
`ifdef AES_SERIAL_ERR_EN
    .err(errA),
`endif
    .busy(busyA)
  );

  aes_serial_port #(.Nb(4), .Nk(8)) dutB (
    .clk(clk), .rst(rst), .cs(csB), .miso(misoB), .mosi(mosiB),
    .blk_data(blkDataB), .blk_key(blkKeyB), .blk_valid(blkValidB), .blk_ready(blkReadyB),
    .res_data(resDataB), .res_valid(resValidB), .res_ready(resReadyB),
`ifdef AES_SERIAL_ERR_EN
    .err(errB),
`endif
    .busy(busyB)
  );

  task automatic checkEq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setLink(input bit which, input logic c, input logic m);
    if (which) begin csB = c; misoB = m; end
    else begin csA = c; misoA = m; end
  endtask

  // Ends just after the edge that sampled the last of nBits bits (cs left low).
  task automatic loadFrame(input bit which, input logic [383:0] bits, input int nBits);
    setLink(which, 1'b1, 1'b0);
    tick();
    setLink(which, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < nBits; k++) begin
      setLink(which, 1'b0, bits[k]);
      tick();
    end
  endtask

  // Collects mosi after edges 0..127; ends just after edge 128.
  task automatic unloadFrame(output logic [127:0] got);
    setLink(1'b0, 1'b1, 1'b0);
    tick();
    setLink(1'b0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 128; k++) begin
      got[k] = mosiA;
      tick();
    end
  endtask

  task automatic pulseReady();
    blkReadyA = 1'b1;
    tick();
    blkReadyA = 1'b0;
  endtask

  task automatic pulseResult(input logic [127:0] r);
    resDataA  = r;
    resValidA = 1'b1;
    tick();
    resValidA = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [383:0] vecPK, vec2, vec8;
    logic [127:0] got, r2, r3, ctv;

    vecPK = {128'h0, FIPS_KEY128, FIPS_PT};
    vec2  = {128'h0, FIPS_PT, FIPS_CT128};
    vec8  = {FIPS_KEY256, FIPS_PT};
    r2    = 128'hdeadbeef_01234567_89abcdef_f0e1d2c3;
    r3    = 128'h80000000_00000000_00000000_00000001;
    ctv   = FIPS_CT128;

    rst = 1'b0;
    csA = 1'b1; misoA = 1'b0; blkReadyA = 1'b0; resValidA = 1'b0; resDataA = '0;
    csB = 1'b1; misoB = 1'b0; blkReadyB = 1'b0; resValidB = 1'b0; resDataB = '0;
    tick();
    tick();
    checkEq("rst_mosi", mosiA, 1'b0);
    checkEq("rst_blk_valid", blkValidA, 1'b0);
    checkEq("rst_res_ready", resReadyA, 1'b0);
    checkEq("rst_busy", busyA, 1'b0);
    checkEq("rst_blk_data", blkDataA, 128'h0);
    checkEq("rst_blk_key", blkKeyA, 128'h0);
`ifdef AES_SERIAL_ERR_EN
    checkEq("rst_err", errA, 1'b0);
`endif
    rst = 1'b1;
    tick();

    // FIPS-197 load: valid only after the edge that takes bit 255 (cycle 256)
    loadFrame(1'b0, vecPK, 255);
    checkEq("ld_busy", busyA, 1'b1);
    checkEq("ld_valid_early", blkValidA, 1'b0);
    setLink(1'b0, 1'b0, vecPK[255]);
    tick();
    checkEq("ld_valid", blkValidA, 1'b1);
    checkEq("ld_data", blkDataA, FIPS_PT);
    checkEq("ld_key", blkKeyA, FIPS_KEY128);
    checkEq("ld_busy_done", busyA, 1'b0);
    setLink(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      tick();
      checkEq("hold_valid", blkValidA, 1'b1);
    end
    checkEq("hold_data", blkDataA, FIPS_PT);
    pulseReady();
    checkEq("xfer_valid", blkValidA, 1'b0);
    checkEq("xfer_res_ready", resReadyA, 1'b1);
    pulseResult(FIPS_CT128);
    checkEq("cap_res_ready", resReadyA, 1'b0);
    unloadFrame(got);
    checkEq("rt_result", got, FIPS_CT128);
    checkEq("rt_tail", mosiA, 1'b0);
`ifdef AES_SERIAL_ERR_EN
    checkEq("rt_err", errA, 1'b0);
`endif

    // Early unload: result already consumed
    loadFrame(1'b0, vec2, 256);
    checkEq("v2_valid", blkValidA, 1'b1);
    checkEq("v2_data", blkDataA, FIPS_CT128);
    unloadFrame(got);
    checkEq("early_mosi", got, 128'h0);
`ifdef AES_SERIAL_ERR_EN
    checkEq("early_err", errA, 1'b1);
`endif
    pulseReady();
    pulseResult(r2);

    // Abort a LOAD at cycle ~100; the interrupting frame is an UNLOAD
    loadFrame(1'b0, vecPK, 99);
    unloadFrame(got);
    checkEq("abort_no_valid", blkValidA, 1'b0);
    checkEq("abort_unload", got, r2);
    loadFrame(1'b0, vecPK, 256);
    checkEq("post_abort_valid", blkValidA, 1'b1);
    checkEq("post_abort_data", blkDataA, FIPS_PT);
    checkEq("post_abort_key", blkKeyA, FIPS_KEY128);

    // Busy core: LOAD while res_ready is high is dropped
    pulseReady();
    unloadFrame(got);
    checkEq("idle_unload", got, 128'h0);
    loadFrame(1'b0, vec2, 256);
    checkEq("busy_valid", blkValidA, 1'b0);
    checkEq("busy_data", blkDataA, FIPS_PT);
    checkEq("busy_key", blkKeyA, FIPS_KEY128);
    checkEq("busy_res_ready", resReadyA, 1'b1);
`ifdef AES_SERIAL_ERR_EN
    checkEq("busy_err", errA, 1'b1);
`endif
    pulseResult(r3);
    unloadFrame(got);
    checkEq("busy_result", got, r3);
    loadFrame(1'b0, vec2, 256);
    checkEq("relaunch_valid", blkValidA, 1'b1);
    checkEq("relaunch_data", blkDataA, FIPS_CT128);

    // Reset in the middle of an UNLOAD at cycle 60
    pulseReady();
    pulseResult(FIPS_CT128);
    setLink(1'b0, 1'b1, 1'b0);
    tick();
    setLink(1'b0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 60; k++) tick();
    checkEq("c60_mosi", mosiA, ctv[60]);
    checkEq("c60_busy", busyA, 1'b1);
    rst = 1'b0;
    setLink(1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    checkEq("mrst_mosi", mosiA, 1'b0);
    checkEq("mrst_busy", busyA, 1'b0);
    checkEq("mrst_blk_valid", blkValidA, 1'b0);
    checkEq("mrst_res_ready", resReadyA, 1'b0);
    checkEq("mrst_blk_data", blkDataA, 128'h0);
`ifdef AES_SERIAL_ERR_EN
    checkEq("mrst_err", errA, 1'b0);
`endif
    loadFrame(1'b0, vecPK, 256);
    checkEq("after_rst_valid", blkValidA, 1'b1);
    checkEq("after_rst_data", blkDataA, FIPS_PT);
    checkEq("after_rst_key", blkKeyA, FIPS_KEY128);

    // Nk=8: 384-bit LOAD frame
    loadFrame(1'b1, vec8, 383);
    checkEq("k8_valid_early", blkValidB, 1'b0);
    checkEq("k8_busy", busyB, 1'b1);
    setLink(1'b1, 1'b0, vec8[383]);
    tick();
    checkEq("k8_valid", blkValidB, 1'b1);
    checkEq("k8_data", blkDataB, FIPS_PT);
    checkEq("k8_key", blkKeyB, FIPS_KEY256);
    checkEq("k8_idle", busyB, 1'b0);
    checkEq("k8_res_ready", resReadyB, 1'b0);
    checkEq("k8_mosi", mosiB, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
